// File: rtl/eth_tx_pkg.sv
// Shared definitions for the UDP transmit path: PHY block size, buffer FSM states, checksum add.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package eth_tx_pkg;

  localparam int BLOCK_N = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_REQ,
    ST_SEND,
    ST_DROP
  } state_e;

  // Ones-complement 16-bit add. The end-around carry is folded back in once.
  // A single fold is enough because the largest sum, 0xFFFF + 0xFFFF = 0x1FFFE,
  // folds to 0xFFFF with no further carry.
  function automatic logic [15:0] cs_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/eth_tx_buf_ram.sv
// Simple dual-port payload store: one write port and one registered read port.
// Latency: read data appears 1 cycle after re_i/raddr_i are sampled.
// Backpressure: none; the caller never reads and writes in the same phase.
module eth_tx_buf_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array and its output register. Neither needs a reset; the buffer
  // FSM masks the read data whenever it is not valid.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/eth_tx_buf.sv
// Store-and-forward staging buffer for eth_tx: captures a payload with its length and checksum, then replays it.
// Latency: early_v is raised 1 cycle after the last source word; payload starts 1 cycle after app_ready_v_i is seen.
// Backpressure: src_ready_o is low from the request until the replay ends; the replay itself never stalls.
module eth_tx_buf #(
  parameter int DATA_W    = 16,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int LEN_W     = $clog2(KEEP_W + 1),
  parameter int PKT_LEN_W = 16,
  parameter int BLOCK_N   = eth_tx_pkg::BLOCK_N,
  parameter int BUF_WORDS = 1024,
  localparam int BLW      = $clog2(BLOCK_N + 1)
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 src_valid_i,
  output logic                 src_ready_o,
  input  logic [DATA_W-1:0]    src_data_i,
  input  logic [LEN_W-1:0]     src_len_i,
  input  logic                 src_last_i,
  input  logic                 src_cancel_i,
  output logic                 src_err_o,
  output logic                 app_early_v_o,
  input  logic                 app_ready_v_i,
  output logic [DATA_W-1:0]    app_data_o,
  output logic [LEN_W-1:0]     app_len_o,
  output logic [PKT_LEN_W-1:0] app_pkt_len_o,
  output logic [15:0]          app_cs_o,
  output logic                 app_last_o,
  output logic                 app_last_block_next_o,
  output logic [BLW-1:0]       app_last_block_next_len_o
);

  import eth_tx_pkg::*;

  localparam int AW    = $clog2(BUF_WORDS);
  localparam int LANES = DATA_W / 16;
  localparam logic [PKT_LEN_W-1:0] KW  = PKT_LEN_W'(KEEP_W);
  localparam logic [PKT_LEN_W-1:0] BLK = PKT_LEN_W'(BLOCK_N);

  state_e               state_q, state_d;
  logic [AW:0]          wr_ptr_q, wr_ptr_d;   // extra MSB flags a wrap past the last word
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [PKT_LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [15:0]          cs_q, cs_d;
  logic                 err_q, err_d;
  logic                 rdy_q, rdy_d;

  logic [15:0]          word_cs;
  logic [7:0]           lane_hi, lane_lo;
  logic [PKT_LEN_W-1:0] byte_sum;
  logic [PKT_LEN_W-1:0] x_off;
  logic [AW:0]          rd_nxt;
  logic                 last_cyc;
  logic                 ram_we, ram_re;
  logic [AW-1:0]        ram_raddr;
  logic [DATA_W-1:0]    ram_rdata;

  assign byte_sum = byte_cnt_q + PKT_LEN_W'(src_len_i);
  assign rd_nxt   = rd_ptr_q + 1'b1;
  assign x_off    = PKT_LEN_W'(rd_ptr_q) * KW;
  assign last_cyc = (state_q == ST_SEND) && (PKT_LEN_W'(rd_ptr_q) == byte_cnt_q / KW);

  // Fold the incoming word's 16-bit lanes into the running sum, zeroing bytes past src_len_i
  always_comb begin
    word_cs = cs_q;
    lane_hi = 8'h00;
    lane_lo = 8'h00;
    for (int k = 0; k < LANES; k++) begin
      lane_hi = (LEN_W'(2 * k) < src_len_i) ? src_data_i[16 * k +: 8] : 8'h00;
      lane_lo = (LEN_W'(2 * k + 1) < src_len_i) ? src_data_i[16 * k + 8 +: 8] : 8'h00;
      word_cs = cs_add(word_cs, {lane_hi, lane_lo});
    end
  end

  // Next state: fill and validate, request the slot, replay, or discard a bad packet
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    byte_cnt_d = byte_cnt_q;
    cs_d       = cs_q;
    err_d      = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_raddr  = '0;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (rdy_q && src_cancel_i) begin
          err_d    = (state_q == ST_FILL) || src_valid_i;
          state_d  = ST_IDLE;
          wr_ptr_d = '0; byte_cnt_d = '0; cs_d = '0;
        end else if (rdy_q && src_valid_i) begin
          ram_we     = !wr_ptr_q[AW];
          wr_ptr_d   = wr_ptr_q + 1'b1;
          byte_cnt_d = byte_sum;
          cs_d       = word_cs;
          state_d    = ST_FILL;
          if (wr_ptr_q[AW] || (!src_last_i && src_len_i != LEN_W'(KEEP_W)) ||
              (src_last_i && byte_sum == '0)) begin
            // A bad last word has already closed the packet; otherwise skip to its end
            err_d    = 1'b1;
            state_d  = src_last_i ? ST_IDLE : ST_DROP;
            wr_ptr_d = '0; byte_cnt_d = '0; cs_d = '0;
          end else if (src_last_i) begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Keep word 0 sitting in the RAM output register until the slot is granted
        ram_re   = 1'b1;
        rd_ptr_d = '0;
        if (app_ready_v_i) state_d = ST_SEND;
      end
      ST_SEND: begin
        // Read one word ahead so the next word is ready as the current one leaves
        ram_re    = 1'b1;
        ram_raddr = rd_nxt[AW-1:0];
        rd_ptr_d  = rd_nxt;
        if (last_cyc) begin
          state_d  = ST_IDLE;
          rd_ptr_d = '0; wr_ptr_d = '0; byte_cnt_d = '0; cs_d = '0;
        end
      end
      ST_DROP: begin
        if (rdy_q && (src_cancel_i || (src_valid_i && src_last_i))) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE) || (state_d == ST_FILL) || (state_d == ST_DROP);
  end

  // State, pointers, running length/checksum and registered handshake outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_cnt_q <= '0;
      cs_q       <= '0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      cs_q       <= cs_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
    end
  end

  // App-side outputs: header fields while requesting or sending, payload and last-block side-band while sending
  always_comb begin
    src_ready_o   = rdy_q;
    src_err_o     = err_q;
    app_early_v_o = (state_q == ST_REQ);
    app_pkt_len_o = '0;
    app_cs_o      = '0;
    if (state_q == ST_REQ || state_q == ST_SEND) begin
      app_pkt_len_o = byte_cnt_q;
      app_cs_o      = cs_q;
    end
    app_data_o = (state_q == ST_SEND) ? ram_rdata : '0;
    app_last_o = last_cyc;
    app_len_o  = '0;
    if (state_q == ST_SEND) app_len_o = last_cyc ? LEN_W'(byte_cnt_q % KW) : LEN_W'(KEEP_W);
    app_last_block_next_o = (state_q == ST_SEND) && !last_cyc && (x_off % BLK == '0) &&
                            (x_off / BLK == byte_cnt_q / BLK);
    app_last_block_next_len_o = app_last_block_next_o ? BLW'(byte_cnt_q % BLK) : '0;
  end

  eth_tx_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_WORDS)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (src_data_i),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_eth_tx_buf.sv
// Directed bench for eth_tx_buf: header, checksum, replay timing, error drops and resets.
// Latency: n/a.
// Backpressure: exercises a held-low app_ready_v_i.
module tb_eth_tx_buf;

  logic        clk = 1'b0;
  logic        nreset;
  logic        src_valid_i, src_ready_o, src_last_i, src_cancel_i, src_err_o;
  logic [15:0] src_data_i;
  logic [1:0]  src_len_i;
  logic        app_early_v_o, app_ready_v_i, app_last_o, app_last_block_next_o;
  logic [15:0] app_data_o, app_pkt_len_o, app_cs_o;
  logic [1:0]  app_len_o;
  logic [3:0]  app_last_block_next_len_o;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  eth_tx_buf dut (
    .clk                       (clk),
    .nreset                    (nreset),
    .src_valid_i               (src_valid_i),
    .src_ready_o               (src_ready_o),
    .src_data_i                (src_data_i),
    .src_len_i                 (src_len_i),
    .src_last_i                (src_last_i),
    .src_cancel_i              (src_cancel_i),
    .src_err_o                 (src_err_o),
    .app_early_v_o             (app_early_v_o),
    .app_ready_v_i             (app_ready_v_i),
    .app_data_o                (app_data_o),
    .app_len_o                 (app_len_o),
    .app_pkt_len_o             (app_pkt_len_o),
    .app_cs_o                  (app_cs_o),
    .app_last_o                (app_last_o),
    .app_last_block_next_o     (app_last_block_next_o),
    .app_last_block_next_len_o (app_last_block_next_len_o)
  );

  task automatic drive(input logic [15:0] d, input logic [1:0] l, input logic last, input logic cancel);
    @(negedge clk);
    src_valid_i = 1'b1; src_data_i = d; src_len_i = l; src_last_i = last; src_cancel_i = cancel;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    src_valid_i = 1'b0; src_data_i = 16'h0; src_len_i = 2'd0; src_last_i = 1'b0; src_cancel_i = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b1; app_ready_v_i = 1'b0;
    src_valid_i = 1'b0; src_data_i = 16'h0; src_len_i = 2'd0; src_last_i = 1'b0; src_cancel_i = 1'b0;
    #2 nreset = 1'b0;
    #1;
    checks++; if (src_ready_o !== 1'b0) $display("FAIL rst_ready: got %b want 0", src_ready_o); else passed++;
    checks++; if (app_early_v_o !== 1'b0) $display("FAIL rst_early_v: got %b want 0", app_early_v_o); else passed++;
    checks++; if (src_err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", src_err_o); else passed++;
    checks++; if (app_pkt_len_o !== 16'd0) $display("FAIL rst_pkt_len: got %h want 0", app_pkt_len_o); else passed++;
    checks++; if (app_cs_o !== 16'd0) $display("FAIL rst_cs: got %h want 0", app_cs_o); else passed++;
    checks++; if (app_last_o !== 1'b0) $display("FAIL rst_last: got %b want 0", app_last_o); else passed++;
    checks++; if (app_len_o !== 2'd0) $display("FAIL rst_len: got %0d want 0", app_len_o); else passed++;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    checks++; if (src_ready_o !== 1'b1) $display("FAIL post_rst_ready: got %b want 1", src_ready_o); else passed++;
  endtask

  task automatic test_5byte();
    drive(16'h0201, 2'd2, 1'b0, 1'b0);
    drive(16'h0403, 2'd2, 1'b0, 1'b0);
    drive(16'h0005, 2'd1, 1'b1, 1'b0);
    idle_cycle();
    checks++; if (app_early_v_o !== 1'b1) $display("FAIL b5_early_v: got %b want 1", app_early_v_o); else passed++;
    checks++; if (src_ready_o !== 1'b0) $display("FAIL b5_src_ready: got %b want 0", src_ready_o); else passed++;
    checks++; if (app_pkt_len_o !== 16'd5) $display("FAIL b5_pkt_len: got %0d want 5", app_pkt_len_o); else passed++;
    checks++; if (app_cs_o !== 16'h0906) $display("FAIL b5_cs: got %h want 0906", app_cs_o); else passed++;
    app_ready_v_i = 1'b1;
    @(negedge clk); app_ready_v_i = 1'b0;
    checks++; if (app_data_o !== 16'h0201) $display("FAIL b5_w0_data: got %h want 0201", app_data_o); else passed++;
    checks++; if (app_len_o !== 2'd2) $display("FAIL b5_w0_len: got %0d want 2", app_len_o); else passed++;
    checks++; if (app_last_block_next_o !== 1'b1) $display("FAIL b5_w0_lbn: got %b want 1", app_last_block_next_o); else passed++;
    checks++; if (app_last_block_next_len_o !== 4'd5) $display("FAIL b5_w0_lbn_len: got %0d want 5", app_last_block_next_len_o); else passed++;
    checks++; if (app_early_v_o !== 1'b0) $display("FAIL b5_w0_early_v: got %b want 0", app_early_v_o); else passed++;
    @(negedge clk);
    checks++; if (app_data_o !== 16'h0403) $display("FAIL b5_w1_data: got %h want 0403", app_data_o); else passed++;
    checks++; if (app_last_block_next_o !== 1'b0) $display("FAIL b5_w1_lbn: got %b want 0", app_last_block_next_o); else passed++;
    checks++; if (app_pkt_len_o !== 16'd5) $display("FAIL b5_w1_pkt_len: got %0d want 5", app_pkt_len_o); else passed++;
    @(negedge clk);
    checks++; if (app_last_o !== 1'b1) $display("FAIL b5_last: got %b want 1", app_last_o); else passed++;
    checks++; if (app_len_o !== 2'd1) $display("FAIL b5_last_len: got %0d want 1", app_len_o); else passed++;
    checks++; if (app_data_o[7:0] !== 8'h05) $display("FAIL b5_last_data: got %h want 05", app_data_o[7:0]); else passed++;
    checks++; if (app_last_block_next_o !== 1'b0) $display("FAIL b5_last_lbn: got %b want 0", app_last_block_next_o); else passed++;
    @(negedge clk);
    checks++; if (app_last_o !== 1'b0) $display("FAIL b5_done_last: got %b want 0", app_last_o); else passed++;
    checks++; if (src_ready_o !== 1'b1) $display("FAIL b5_done_ready: got %b want 1", src_ready_o); else passed++;
  endtask

  task automatic test_cs_carry();
    drive(16'hFFFF, 2'd2, 1'b0, 1'b0);
    drive(16'h0200, 2'd2, 1'b0, 1'b0);
    drive(16'h0000, 2'd0, 1'b1, 1'b0);
    idle_cycle();
    checks++; if (app_cs_o !== 16'h0002) $display("FAIL cc_cs: got %h want 0002", app_cs_o); else passed++;
    checks++; if (app_pkt_len_o !== 16'd4) $display("FAIL cc_pkt_len: got %0d want 4", app_pkt_len_o); else passed++;
    app_ready_v_i = 1'b1;
    @(negedge clk); app_ready_v_i = 1'b0;
    checks++; if (app_data_o !== 16'hFFFF) $display("FAIL cc_w0_data: got %h want FFFF", app_data_o); else passed++;
    checks++; if (app_last_block_next_len_o !== 4'd4) $display("FAIL cc_w0_lbn_len: got %0d want 4", app_last_block_next_len_o); else passed++;
    @(negedge clk);
    checks++; if (app_data_o !== 16'h0200 || app_len_o !== 2'd2) $display("FAIL cc_w1: got %h/%0d want 0200/2", app_data_o, app_len_o); else passed++;
    checks++; if (app_last_o !== 1'b0) $display("FAIL cc_w1_last: got %b want 0", app_last_o); else passed++;
    @(negedge clk);
    checks++; if (app_last_o !== 1'b1 || app_len_o !== 2'd0) $display("FAIL cc_last: got %b/%0d want 1/0", app_last_o, app_len_o); else passed++;
    @(negedge clk);
  endtask

  task automatic test_held_ready();
    drive(16'h1234, 2'd2, 1'b0, 1'b0);
    drive(16'h0056, 2'd1, 1'b1, 1'b0);
    idle_cycle();
    for (int i = 0; i < 7; i++) begin
      checks++; if (app_early_v_o !== 1'b1) $display("FAIL hr_early_v[%0d]: got %b want 1", i, app_early_v_o); else passed++;
      checks++; if (app_pkt_len_o !== 16'd3) $display("FAIL hr_pkt_len[%0d]: got %0d want 3", i, app_pkt_len_o); else passed++;
      checks++; if (app_cs_o !== 16'h8A12) $display("FAIL hr_cs[%0d]: got %h want 8A12", i, app_cs_o); else passed++;
      @(negedge clk);
    end
    app_ready_v_i = 1'b1;
    @(negedge clk); app_ready_v_i = 1'b0;
    checks++; if (app_data_o !== 16'h1234) $display("FAIL hr_w0_data: got %h want 1234", app_data_o); else passed++;
    checks++; if (app_last_block_next_len_o !== 4'd3) $display("FAIL hr_w0_lbn_len: got %0d want 3", app_last_block_next_len_o); else passed++;
    @(negedge clk);
    checks++; if (app_last_o !== 1'b1 || app_data_o[7:0] !== 8'h56) $display("FAIL hr_last: got %b/%h want 1/56", app_last_o, app_data_o[7:0]); else passed++;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    logic saw_ev;
    saw_ev = 1'b0;
    for (int i = 0; i < 1025; i++) begin
      drive(16'(i), 2'd2, (i == 1024), 1'b0);
      if (app_early_v_o) saw_ev = 1'b1;
    end
    idle_cycle();
    checks++; if (src_err_o !== 1'b1) $display("FAIL ovf_err: got %b want 1", src_err_o); else passed++;
    idle_cycle();
    checks++; if (src_err_o !== 1'b0) $display("FAIL ovf_err_pulse: got %b want 0", src_err_o); else passed++;
    if (app_early_v_o) saw_ev = 1'b1;
    checks++; if (saw_ev !== 1'b0) $display("FAIL ovf_no_early_v: got %b want 0", saw_ev); else passed++;
    drive(16'hBEEF, 2'd2, 1'b0, 1'b0);
    drive(16'h00AA, 2'd1, 1'b1, 1'b0);
    idle_cycle();
    checks++; if (app_pkt_len_o !== 16'd3 || app_cs_o !== 16'h99BF) $display("FAIL ovf_next_hdr: got %0d/%h want 3/99BF", app_pkt_len_o, app_cs_o); else passed++;
    app_ready_v_i = 1'b1;
    @(negedge clk); app_ready_v_i = 1'b0;
    checks++; if (app_data_o !== 16'hBEEF) $display("FAIL ovf_next_w0: got %h want BEEF", app_data_o); else passed++;
    @(negedge clk);
    checks++; if (app_last_o !== 1'b1 || app_data_o[7:0] !== 8'hAA) $display("FAIL ovf_next_last: got %b/%h want 1/AA", app_last_o, app_data_o[7:0]); else passed++;
    @(negedge clk);
    // zero-byte packet
    drive(16'h0000, 2'd0, 1'b1, 1'b0);
    idle_cycle();
    checks++; if (src_err_o !== 1'b1) $display("FAIL zero_err: got %b want 1", src_err_o); else passed++;
    checks++; if (app_early_v_o !== 1'b0) $display("FAIL zero_early_v: got %b want 0", app_early_v_o); else passed++;
    idle_cycle();
    checks++; if (src_err_o !== 1'b0 || src_ready_o !== 1'b1) $display("FAIL zero_after: got err %b rdy %b want 0/1", src_err_o, src_ready_o); else passed++;
  endtask

  task automatic test_cancel();
    drive(16'h1111, 2'd2, 1'b0, 1'b0);
    drive(16'h2222, 2'd2, 1'b0, 1'b0);
    drive(16'h3333, 2'd2, 1'b0, 1'b0);
    drive(16'h4444, 2'd2, 1'b0, 1'b1);
    idle_cycle();
    checks++; if (src_err_o !== 1'b1) $display("FAIL cxl_err: got %b want 1", src_err_o); else passed++;
    checks++; if (src_ready_o !== 1'b1 || app_early_v_o !== 1'b0) $display("FAIL cxl_idle: got rdy %b ev %b want 1/0", src_ready_o, app_early_v_o); else passed++;
    idle_cycle();
    checks++; if (src_err_o !== 1'b0) $display("FAIL cxl_err_pulse: got %b want 0", src_err_o); else passed++;
    drive(16'h7788, 2'd2, 1'b1, 1'b0);
    idle_cycle();
    checks++; if (app_pkt_len_o !== 16'd2 || app_cs_o !== 16'h8877) $display("FAIL cxl_next_hdr: got %0d/%h want 2/8877", app_pkt_len_o, app_cs_o); else passed++;
    app_ready_v_i = 1'b1;
    @(negedge clk); app_ready_v_i = 1'b0;
    checks++; if (app_data_o !== 16'h7788) $display("FAIL cxl_next_w0: got %h want 7788", app_data_o); else passed++;
    @(negedge clk);
    checks++; if (app_last_o !== 1'b1 || app_len_o !== 2'd0) $display("FAIL cxl_next_last: got %b/%0d want 1/0", app_last_o, app_len_o); else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_send();
    drive(16'hA1A0, 2'd2, 1'b0, 1'b0);
    drive(16'hA3A2, 2'd2, 1'b0, 1'b0);
    drive(16'hA5A4, 2'd2, 1'b0, 1'b0);
    drive(16'h00A6, 2'd1, 1'b1, 1'b0);
    idle_cycle();
    checks++; if (app_pkt_len_o !== 16'd7 || app_cs_o !== 16'h8DEB) $display("FAIL rms_hdr: got %0d/%h want 7/8DEB", app_pkt_len_o, app_cs_o); else passed++;
    app_ready_v_i = 1'b1;
    @(negedge clk); app_ready_v_i = 1'b0;
    checks++; if (app_data_o !== 16'hA1A0 || app_last_block_next_len_o !== 4'd7) $display("FAIL rms_w0: got %h/%0d want A1A0/7", app_data_o, app_last_block_next_len_o); else passed++;
    @(negedge clk);
    @(negedge clk);
    checks++; if (app_data_o !== 16'hA5A4) $display("FAIL rms_w2: got %h want A5A4", app_data_o); else passed++;
    nreset = 1'b0;
    #1;
    checks++; if (app_data_o !== 16'h0 || app_len_o !== 2'd0 || app_last_o !== 1'b0) $display("FAIL rms_rst_data: got %h/%0d/%b want 0/0/0", app_data_o, app_len_o, app_last_o); else passed++;
    checks++; if (app_pkt_len_o !== 16'd0 || app_cs_o !== 16'd0 || app_early_v_o !== 1'b0) $display("FAIL rms_rst_hdr: got %0d/%h/%b want 0/0/0", app_pkt_len_o, app_cs_o, app_early_v_o); else passed++;
    checks++; if (src_ready_o !== 1'b0 || src_err_o !== 1'b0 || app_last_block_next_o !== 1'b0) $display("FAIL rms_rst_src: got %b/%b/%b want 0/0/0", src_ready_o, src_err_o, app_last_block_next_o); else passed++;
    @(negedge clk); nreset = 1'b1;
    idle_cycle();
    drive(16'h0C0B, 2'd2, 1'b0, 1'b0);
    drive(16'h000D, 2'd1, 1'b1, 1'b0);
    idle_cycle();
    checks++; if (app_pkt_len_o !== 16'd3 || app_cs_o !== 16'h180C) $display("FAIL rms_next_hdr: got %0d/%h want 3/180C", app_pkt_len_o, app_cs_o); else passed++;
    app_ready_v_i = 1'b1;
    @(negedge clk); app_ready_v_i = 1'b0;
    checks++; if (app_data_o !== 16'h0C0B) $display("FAIL rms_next_w0: got %h want 0C0B", app_data_o); else passed++;
    @(negedge clk);
    checks++; if (app_last_o !== 1'b1 || app_data_o[7:0] !== 8'h0D) $display("FAIL rms_next_last: got %b/%h want 1/0D", app_last_o, app_data_o[7:0]); else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_5byte();
    test_cs_carry();
    test_held_ready();
    test_overflow();
    test_cancel();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
